neuron_mac: RTL and testbench

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/neuron_pkg.sv | 20 ++
 rtl/neuron_act.sv | 39 +++
 rtl/neuron_mac.sv | 136 +++++++++++++
 tb/tb_neuron_mac.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module   : neuron_pkg
// Brief    : Shared state type and default sizing for the neuron MAC.
// Revision : 1.0
// ============================================================================
package neuron_pkg;

    localparam int c_data_w   = 8;
    localparam int c_n_inputs = 4;
    localparam int c_frac_w   = 4;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_BIAS  = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/neuron_act.sv
`default_nettype none
// ============================================================================
// Module   : neuron_act
// Brief    : Fixed-point rescale (floor), optional ReLU and signed saturation.
// Revision : 1.0
// ============================================================================
module neuron_act #(
    parameter int ACC_W  = 21,
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic              i_relu_en,
    output logic [DATA_W-1:0] o_y,
    output logic              o_sat
);

    localparam logic signed [ACC_W-1:0] c_max = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_min = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] w_shift;
    logic signed [ACC_W-1:0] w_relu;

    always_comb begin
        w_shift = $signed(i_acc) >>> FRAC_W;
        w_relu  = (i_relu_en && w_shift[ACC_W-1]) ? '0 : w_shift;
        o_y     = w_relu[DATA_W-1:0];
        o_sat   = 1'b0;
        if (w_relu > c_max) begin
            o_y   = c_max[DATA_W-1:0];
            o_sat = 1'b1;
        end else if (w_relu < c_min) begin
            o_y   = c_min[DATA_W-1:0];
            o_sat = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : neuron_mac
// Brief    : Streaming multiply-accumulate neuron with bias, ReLU and saturation.
// Revision : 1.0
// ============================================================================
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int DATA_W   = c_data_w,
    parameter int N_INPUTS = c_n_inputs,
    parameter int FRAC_W   = c_frac_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] bias,
    input  logic              relu_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y,
    output logic              sat
);

    localparam int ACC_W = 2*DATA_W + $clog2(N_INPUTS) + 1;
    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(N_INPUTS - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic [DATA_W-1:0]       r_bias;
    logic                    r_relu;
    logic [DATA_W-1:0]       r_y;
    logic                    r_sat;
    logic                    r_out_valid;

    logic signed [2*DATA_W-1:0] w_x_ext;
    logic signed [2*DATA_W-1:0] w_w_ext;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_bias_wide;
    logic signed [ACC_W-1:0]    w_bias_ext;
    logic signed [ACC_W-1:0]    w_acc_biased;
    logic [DATA_W-1:0]          w_act_y;
    logic                       w_act_sat;
    logic                       w_beat;

    // Low 2*DATA_W bits of the widened product equal the exact signed product.
    assign w_x_ext      = {{DATA_W{x[DATA_W-1]}}, x};
    assign w_w_ext      = {{DATA_W{weight[DATA_W-1]}}, weight};
    assign w_prod       = w_x_ext * w_w_ext;
    assign w_prod_ext   = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_bias_wide  = {{(ACC_W-DATA_W){r_bias[DATA_W-1]}}, r_bias};
    assign w_bias_ext   = w_bias_wide <<< FRAC_W;
    assign w_acc_biased = r_acc + w_bias_ext;

    assign in_ready  = (r_state == ST_ACCUM) && en;
    assign w_beat    = in_ready && in_valid;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign sat       = r_sat;

    neuron_act #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_act (
        .i_acc     (w_acc_biased),
        .i_relu_en (r_relu),
        .o_y       (w_act_y),
        .o_sat     (w_act_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: if (w_beat && (r_cnt == c_last)) w_state_next = ST_BIAS;
            ST_BIAS:  if (en) w_state_next = ST_OUT;
            ST_OUT:   if (en && out_ready) w_state_next = ST_ACCUM;
            default:  w_state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_bias      <= '0;
            r_relu      <= 1'b0;
            r_y         <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (en) begin
            case (r_state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        if (r_cnt == '0) begin
                            r_acc  <= w_prod_ext;
                            r_bias <= bias;
                            r_relu <= relu_en;
                        end else begin
                            r_acc <= r_acc + w_prod_ext;
                        end
                        r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
                    end
                end
                ST_BIAS: begin
                    r_acc       <= w_acc_biased;
                    r_y         <= w_act_y;
                    r_sat       <= w_act_sat;
                    r_out_valid <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_mac
// Brief    : Self-checking bench for neuron_mac against a vector-level model.
// Revision : 1.0
// ============================================================================
module tb_neuron_mac;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int F  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] x;
    logic [DW-1:0] weight;
    logic [DW-1:0] bias;
    logic          relu_en;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] y;
    logic          sat;

    always #5 clk = ~clk;

    neuron_mac #(
        .DATA_W   (DW),
        .N_INPUTS (N),
        .FRAC_W   (F)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .weight    (weight),
        .bias      (bias),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .sat       (sat)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    localparam longint c_hi = (longint'(1) <<< (DW-1)) - 1;
    localparam longint c_lo = -(longint'(1) <<< (DW-1));

    function automatic longint ref_pre(input longint total, input bit relu);
        longint v;
        v = total >>> F;
        if (relu && v < 0) v = 0;
        return v;
    endfunction

    function automatic longint ref_y(input longint total, input bit relu);
        longint v;
        v = ref_pre(total, relu);
        if (v > c_hi) return c_hi;
        if (v < c_lo) return c_lo;
        return v;
    endfunction

    function automatic bit ref_sat(input longint total, input bit relu);
        longint v;
        v = ref_pre(total, relu);
        return (v > c_hi) || (v < c_lo);
    endfunction

    // Vector-level reference: gather N accepted products, then one idle
    // enabled cycle for the bias, then a result waits until consumed.
    typedef struct {
        longint ry;
        bit     rs;
    } res_t;

    res_t   exp_q[$];
    longint m_sum;
    longint m_bias;
    bit     m_relu;
    int     m_beats = 0;
    bit     m_bias_due = 1'b0;
    bit     started = 1'b0;

    initial forever begin
        longint total;
        res_t   r;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_beats    = 0;
            m_bias_due = 1'b0;
            started    = 1'b1;
        end else if (en) begin
            if (exp_q.size() != 0) begin
                if (out_ready) void'(exp_q.pop_front());
            end else if (m_bias_due) begin
                total = m_sum + (m_bias <<< F);
                r.ry  = ref_y(total, m_relu);
                r.rs  = ref_sat(total, m_relu);
                exp_q.push_back(r);
                m_bias_due = 1'b0;
            end else if (in_valid) begin
                if (m_beats == 0) begin
                    m_sum  = 0;
                    m_bias = longint'($signed(bias));
                    m_relu = relu_en;
                end
                m_sum += longint'($signed(x)) * longint'($signed(weight));
                m_beats++;
                if (m_beats == N) begin
                    m_beats    = 0;
                    m_bias_due = 1'b1;
                end
            end
        end
    end

    initial forever begin
        bit exp_rdy;
        @(negedge clk);
        if (started) begin
            exp_rdy = (exp_q.size() == 0) && !m_bias_due && en;
            chk("cmp_out_valid", longint'(out_valid), longint'(exp_q.size() != 0));
            chk("cmp_in_ready", longint'(in_ready), longint'(exp_rdy));
            if (exp_q.size() != 0) begin
                chk("cmp_y", longint'($signed(y)), exp_q[0].ry);
                chk("cmp_sat", longint'(sat), longint'(exp_q[0].rs));
            end
        end
    end

    task automatic run_vec(input int xv, input int wv, input int bv, input bit rv,
                           input longint ey, input bit es, input int hold, input int stall);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            x        = DW'(xv);
            weight   = DW'(wv);
            if (i == 0) begin
                bias    = DW'(bv);
                relu_en = rv;
            end else begin
                bias    = DW'($urandom);
                relu_en = 1'(~rv);
            end
            @(posedge clk);
            #1;
            if (i == 1 && stall > 0) begin
                en = 1'b0;
                x  = DW'($urandom);
                repeat (stall) begin
                    @(posedge clk);
                    #1;
                end
                en = 1'b1;
            end
        end
        in_valid = 1'b0;
        chk("ov_not_early", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("ov_on_time", longint'(out_valid), 1);
        chk("y_literal", longint'($signed(y)), ey);
        chk("sat_literal", longint'(sat), longint'(es));
        if (hold > 0) begin
            in_valid = 1'b1;
            x        = DW'(100);
            repeat (hold) begin
                @(posedge clk);
                #1;
                chk("hold_ov", longint'(out_valid), 1);
                chk("hold_y", longint'($signed(y)), ey);
                chk("hold_sat", longint'(sat), longint'(es));
                chk("hold_in_ready", longint'(in_ready), 0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("ov_cleared", longint'(out_valid), 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; weight = '0; bias = '0; relu_en = 1'b0;

        chk("pin_model_80", ref_y(4*256 + 256, 1'b0), 80);
        chk("pin_model_hi", ref_y(4*127*127, 1'b0), 127);
        chk("pin_model_hisat", longint'(ref_sat(4*127*127, 1'b0)), 1);
        chk("pin_model_lo", ref_y(-4*128*127, 1'b0), -128);
        chk("pin_model_neg", ref_y(-1024, 1'b0), -64);
        chk("pin_model_relu", ref_y(-1024, 1'b1), 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_y", longint'(y), 0);
        chk("rst_sat", longint'(sat), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        rst = 1'b0;

        run_vec(16, 16, 16, 1'b0, 80, 1'b0, 0, 0);
        run_vec(127, 127, 0, 1'b0, 127, 1'b1, 0, 0);
        run_vec(-128, 127, 0, 1'b0, -128, 1'b1, 0, 0);
        run_vec(-16, 16, 0, 1'b0, -64, 1'b0, 0, 0);
        run_vec(-16, 16, 0, 1'b1, 0, 1'b0, 0, 0);
        run_vec(16, 16, 16, 1'b0, 80, 1'b0, 5, 0);
        run_vec(-16, 16, 0, 1'b0, -64, 1'b0, 0, 0);

        // Abandon a half-filled vector with reset; no residue may survive.
        in_valid = 1'b1; x = DW'(16); weight = DW'(16); bias = DW'(16);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_ov", longint'(out_valid), 0);
        run_vec(16, 16, 0, 1'b0, 64, 1'b0, 0, 0);
        run_vec(16, 16, 16, 1'b0, 80, 1'b0, 0, 3);

        repeat (600) begin
            rst       = ($urandom_range(0, 99) == 0);
            en        = ($urandom_range(0, 99) < 85);
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 50);
            x         = DW'($urandom);
            weight    = DW'($urandom);
            bias      = DW'($urandom);
            relu_en   = 1'($urandom);
            @(posedge clk);
            #1;
        end

        rst = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("drain_ov", longint'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
